// File: rtl/conv_window_gen.sv
// Streaming CIN x F x F sliding-window generator over a raster pixel stream (valid conv, stride 1).
// Define CONV_WINDOW_STRIDE2_EN to emit only every second window in both directions (stride 2).
module conv_window_gen #(
   parameter int WIDTH = 8,
   parameter int F     = 5,
   parameter int CIN   = 3,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CIN*WIDTH-1:0] in_pix,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     x [0:CIN*F*F-1],
   output logic                 out_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

`ifdef CONV_WINDOW_STRIDE2_EN
   localparam int LAST_ROW = (F - 1) + 2 * ((IMG_H - F) / 2);
   localparam int LAST_COL = (F - 1) + 2 * ((IMG_W - F) / 2);
`else
   localparam int LAST_ROW = IMG_H - 1;
   localparam int LAST_COL = IMG_W - 1;
`endif

   localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(F - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(F - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(LAST_COL);
   localparam logic [RW-1:0] ROW_LAST  = RW'(LAST_ROW);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          accept;
   logic          in_window;
   logic          emit;
   logic          is_last;

   // Each line-buffer column holds the F-1 previous rows at that column, oldest at index 0.
   logic [CIN*WIDTH-1:0] lb      [IMG_W][F-1];
   logic [CIN*WIDTH-1:0] col_in  [F];
   logic [WIDTH-1:0]     win     [CIN][F][F];
   logic [WIDTH-1:0]     win_next[CIN][F][F];

   always_comb begin
      in_ready  = !out_valid || out_ready;
      accept    = in_valid && in_ready;
      in_window = (row >= ROW_FIRST) && (col >= COL_FIRST);
`ifdef CONV_WINDOW_STRIDE2_EN
      emit      = in_window && (row[0] == ROW_FIRST[0]) && (col[0] == COL_FIRST[0]);
`else
      emit      = in_window;
`endif
      is_last   = (row == ROW_LAST) && (col == COL_LAST);
   end

   always_comb begin
      for (int r = 0; r < F - 1; r++) begin
         col_in[r] = lb[col][r];
      end
      col_in[F-1] = in_pix;
   end

   // Window shifts left; the new right column comes from the line-buffer taps plus the incoming pixel.
   always_comb begin
      for (int c = 0; c < CIN; c++) begin
         for (int r = 0; r < F; r++) begin
            for (int k = 0; k < F - 1; k++) begin
               win_next[c][r][k] = win[c][r][k+1];
            end
            win_next[c][r][F-1] = col_in[r][c*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         for (int i = 0; i < CIN * F * F; i++) begin
            x[i] <= '0;
         end
         for (int c = 0; c < CIN; c++) begin
            for (int r = 0; r < F; r++) begin
               for (int k = 0; k < F; k++) begin
                  win[c][r][k] <= '0;
               end
            end
         end
      end else if (accept) begin
         for (int c = 0; c < CIN; c++) begin
            for (int r = 0; r < F; r++) begin
               for (int k = 0; k < F; k++) begin
                  win[c][r][k] <= win_next[c][r][k];
                  if (emit) begin
                     x[(c * F + r) * F + k] <= win_next[c][r][k];
                  end
               end
            end
         end
         out_valid <= emit;
         out_last  <= emit && is_last;
         if (col == COL_MAX) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   // Read-before-write at the same column: taps above see the old contents this cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < F - 2; r++) begin
            lb[col][r] <= lb[col][r+1];
         end
         lb[col][F-2] <= in_pix;
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on an 8x8, 3-channel, 5x5 configuration.
// Expected windows are pushed to a scoreboard on pixel acceptance and compared when emitted.
module tb_conv_window_gen;

   localparam int W   = 8;
   localparam int F   = 5;
   localparam int CIN = 3;
   localparam int IW  = 8;
   localparam int IH  = 8;
   localparam int N   = CIN * F * F;
`ifdef CONV_WINDOW_STRIDE2_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int WPF    = ((IH - F) / STEP + 1) * ((IW - F) / STEP + 1);
   localparam int LAST_R = (F - 1) + STEP * ((IH - F) / STEP);
   localparam int LAST_C = (F - 1) + STEP * ((IW - F) / STEP);

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [CIN*W-1:0]   in_pix;
   logic               out_valid;
   logic               out_ready;
   logic [W-1:0]       x [0:N-1];
   logic               out_last;

   typedef struct {
      int r;
      int c;
      bit last;
   } win_t;

   win_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   wins     = 0;
   int   mrow     = 0;
   int   mcol     = 0;

   conv_window_gen #(
      .WIDTH(W), .F(F), .CIN(CIN), .IMG_W(IW), .IMG_H(IH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pix   (in_pix),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .x        (x),
      .out_last (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pval(input int ch, input int r, input int c);
      logic [7:0] b;
      b = 8'(r * 16 + c);
      case (ch)
         0:       return b;
         1:       return b + 8'h80;
         default: return b ^ 8'hFF;
      endcase
   endfunction

   function automatic bit modelEmit(input int r, input int c);
      return (r >= F - 1) && (c >= F - 1) &&
             (((r - (F - 1)) % STEP) == 0) && (((c - (F - 1)) % STEP) == 0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: pop on output handshake, push on input handshake.
   always @(negedge clk) begin
      win_t w;
      int   mism;
      if (rst) begin
         mrow = 0;
         mcol = 0;
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_window", 32'd1, 32'd0);
            end else begin
               w = sb.pop_front();
               wins++;
               mism = 0;
               for (int c = 0; c < CIN; c++)
                  for (int r = 0; r < F; r++)
                     for (int k = 0; k < F; k++)
                        if (x[(c * F + r) * F + k] !== pval(c, w.r - (F - 1) + r, w.c - (F - 1) + k))
                           mism++;
               checkOutput("window_mismatches", mism, 0);
               checkOutput("x0", x[0], pval(0, w.r - (F - 1), w.c - (F - 1)));
               checkOutput("x24", x[24], pval(0, w.r, w.c));
               checkOutput("out_last", out_last, w.last);
            end
         end
         if (in_valid && in_ready) begin
            if (modelEmit(mrow, mcol)) begin
               sb.push_back('{r: mrow, c: mcol, last: (mrow == LAST_R) && (mcol == LAST_C)});
            end
            if (mcol == IW - 1) begin
               mcol = 0;
               mrow = (mrow == IH - 1) ? 0 : mrow + 1;
            end else begin
               mcol++;
            end
         end
      end
   end

   task automatic waitAccept();
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) checkOutput("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit bursty, input bit stall, input bit first_checks,
                                input int stop_r, input int stop_c);
      for (int r = 0; r < IH; r++) begin
         for (int c = 0; c < IW; c++) begin
            if (bursty) begin
               while ($urandom_range(0, 1) == 1) begin
                  in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
            end
            in_valid = 1'b1;
            in_pix   = {pval(2, r, c), pval(1, r, c), pval(0, r, c)};
            waitAccept();
            checkOutput("valid_after_pixel", out_valid, modelEmit(r, c));
            if (first_checks && r == 4 && c == 4) begin
               checkOutput("first_x0", x[0], 8'h00);
               checkOutput("first_x4", x[4], 8'h04);
               checkOutput("first_x20", x[20], 8'h40);
               checkOutput("first_x24", x[24], 8'h44);
               checkOutput("first_x25", x[25], 8'h80);
               checkOutput("first_x50", x[50], 8'hFF);
            end
            if (stall && r == 4 && c == 4) begin
               out_ready = 1'b0;
               in_valid  = 1'b1;
               in_pix    = {pval(2, 4, 5), pval(1, 4, 5), pval(0, 4, 5)};
               repeat (5) begin
                  @(negedge clk);
                  checkOutput("stall_in_ready", in_ready, 1'b0);
                  checkOutput("stall_out_valid", out_valid, 1'b1);
                  checkOutput("stall_x24", x[24], 8'h44);
                  @(posedge clk);
                  #1;
               end
               out_ready = 1'b1;
            end
            if (r == stop_r && c == stop_c) begin
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
      checkOutput("drained_out_valid", out_valid, 1'b0);
      checkOutput("scoreboard_empty", sb.size(), 0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_pix    = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_out_last", out_last, 1'b0);
      checkOutput("reset_x0", x[0], 8'h00);
      checkOutput("reset_x74", x[N-1], 8'h00);
      checkOutput("reset_in_ready", in_ready, 1'b1);
      rst = 1'b0;

      $display("[TB] ramp frame");
      wins = 0;
      applyStimulus(1'b0, 1'b0, 1'b1, -1, -1);
      drain();
      checkOutput("ramp_count", wins, WPF);

      $display("[TB] backpressure frame");
      wins = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, -1, -1);
      drain();
      checkOutput("stall_count", wins, WPF);

      $display("[TB] bursty frame");
      wins = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, -1, -1);
      drain();
      checkOutput("bursty_count", wins, WPF);

      $display("[TB] back-to-back frames");
      wins = 0;
      applyStimulus(1'b0, 1'b0, 1'b0, -1, -1);
      applyStimulus(1'b0, 1'b0, 1'b1, -1, -1);
      drain();
      checkOutput("b2b_count", wins, 2 * WPF);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b0, 1'b0, 1'b0, 5, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_out_valid", out_valid, 1'b0);
      checkOutput("midreset_out_last", out_last, 1'b0);
      rst  = 1'b0;
      wins = 0;
      applyStimulus(1'b0, 1'b0, 1'b1, -1, -1);
      drain();
      checkOutput("after_reset_count", wins, WPF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

endmodule
